zap_data_access_ctrl: RTL and testbench

//  Sequences one data-memory access per load/store from the execute stage onto the D-cache/Wishbone port.

---
 rtl/zap_data_access_ctrl_pkg.sv | 28 ++
 rtl/zap_lane_steer.sv | 47 ++++
 rtl/zap_data_access_ctrl.sv | 142 ++++++++++++++
 tb/tb_zap_data_access_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_data_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zap_data_access_ctrl_pkg                                             |
// | State encodings, access size codes and fault-cause codes shared by   |
// | the data access controller and its lane steering logic.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package zap_data_access_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ABORT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] c_SIZE_WORD = 2'd0;
  localparam logic [1:0] c_SIZE_HALF = 2'd1;
  localparam logic [1:0] c_SIZE_BYTE = 2'd2;
  localparam logic [1:0] c_SIZE_RSVD = 2'd3;

  localparam logic [1:0] c_CAUSE_NONE     = 2'd0;
  localparam logic [1:0] c_CAUSE_BUS      = 2'd1;
  localparam logic [1:0] c_CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] c_CAUSE_TIMEOUT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/zap_lane_steer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zap_lane_steer                                                       |
// | Maps access size and low address bits to byte selects, replicated    |
// | store data and a misalignment flag.                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module zap_lane_steer
  import zap_data_access_ctrl_pkg::*;
#(
  parameter int ALIGN_CHK = 1
) (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_sel        = 4'h0;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_size)
      c_SIZE_WORD: begin
        o_sel        = 4'hF;
        o_misaligned = (ALIGN_CHK != 0) && (i_addr_lo != 2'b00);
      end
      c_SIZE_HALF: begin
        o_sel        = i_addr_lo[1] ? 4'hC : 4'h3;
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = (ALIGN_CHK != 0) && i_addr_lo[0];
      end
      // Reserved size code behaves as a byte access.
      c_SIZE_BYTE, c_SIZE_RSVD: begin
        o_sel   = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      default: begin
        o_sel = 4'h0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/zap_data_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zap_data_access_ctrl                                                 |
// | Issues one D-cache/Wishbone access per load/store and stalls the     |
// | pipeline until the raw read word and fault status are available.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module zap_data_access_ctrl
  import zap_data_access_ctrl_pkg::*;
#(
  parameter int ALIGN_CHK      = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_code_stall,
  input  logic        i_clear_from_writeback,
  input  logic        i_req_valid,
  input  logic        i_req_load,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  output logic        o_dc_stb,
  output logic        o_dc_we,
  output logic [31:0] o_dc_addr,
  output logic [3:0]  o_dc_sel,
  output logic [31:0] o_dc_wdata,
  input  logic        i_dc_ack,
  input  logic        i_dc_err,
  input  logic [31:0] i_dc_rdata,
  output logic        o_data_stall,
  output logic [31:0] o_rd_data,
  output logic        o_fault,
  output logic [1:0]  o_fault_cause
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;

  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;
  logic        w_end;

  zap_lane_steer #(
    .ALIGN_CHK (ALIGN_CHK)
  ) u_lane_steer (
    .i_size       (i_req_size),
    .i_addr_lo    (i_req_addr[1:0]),
    .i_wdata      (i_req_wdata),
    .o_sel        (w_sel),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  assign w_start   = i_req_valid & ~i_clear_from_writeback & ~i_code_stall;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);
  assign w_end     = i_dc_ack | i_dc_err | w_timeout;

  assign o_data_stall = ~i_clear_from_writeback &
                        (((r_state == S_IDLE) & i_req_valid) | (r_state == S_ACCESS));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      o_dc_stb      <= 1'b0;
      o_dc_we       <= 1'b0;
      o_dc_addr     <= 32'h0;
      o_dc_sel      <= 4'h0;
      o_dc_wdata    <= 32'h0;
      o_rd_data     <= 32'h0;
      o_fault       <= 1'b0;
      o_fault_cause <= c_CAUSE_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (w_misaligned) begin
              r_state       <= S_DONE;
              o_fault       <= 1'b1;
              o_fault_cause <= c_CAUSE_MISALIGN;
            end else begin
              r_state    <= S_ACCESS;
              r_cnt      <= '0;
              o_dc_stb   <= 1'b1;
              o_dc_we    <= ~i_req_load;
              o_dc_addr  <= {i_req_addr[31:2], 2'b00};
              o_dc_sel   <= w_sel;
              o_dc_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS, S_ABORT: begin
          if (w_end) begin
            o_dc_stb <= 1'b0;
            // A flush coinciding with termination discards the result directly.
            if ((r_state == S_ACCESS) && !i_clear_from_writeback) begin
              r_state <= S_DONE;
              if (i_dc_err) begin
                o_fault       <= 1'b1;
                o_fault_cause <= c_CAUSE_BUS;
              end else if (i_dc_ack) begin
                if (!o_dc_we) begin
                  o_rd_data <= i_dc_rdata;
                end
              end else begin
                o_fault       <= 1'b1;
                o_fault_cause <= c_CAUSE_TIMEOUT;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (i_clear_from_writeback) begin
              r_state <= S_ABORT;
            end
          end
        end
        S_DONE: begin
          if (i_clear_from_writeback || !i_code_stall) begin
            r_state       <= S_IDLE;
            o_fault       <= 1'b0;
            o_fault_cause <= c_CAUSE_NONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zap_data_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_zap_data_access_ctrl                                              |
// | Directed and randomized checks against a transaction-level model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_zap_data_access_ctrl;

  localparam int ALIGN_CHK      = 1;
  localparam int TIMEOUT_CYCLES = 256;
  localparam int PH_IDLE = 0, PH_BUS = 1, PH_DRAIN = 2, PH_RESULT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, cstall, valid, load, ack, err;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;
  wire         o_dc_stb, o_dc_we, o_data_stall, o_fault;
  wire  [31:0] o_dc_addr, o_dc_wdata, o_rd_data;
  wire  [3:0]  o_dc_sel;
  wire  [1:0]  o_fault_cause;

  zap_data_access_ctrl #(
    .ALIGN_CHK      (ALIGN_CHK),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_code_stall           (cstall),
    .i_clear_from_writeback (clear),
    .i_req_valid            (valid),
    .i_req_load             (load),
    .i_req_addr             (addr),
    .i_req_wdata            (wdata),
    .i_req_size             (size),
    .o_dc_stb               (o_dc_stb),
    .o_dc_we                (o_dc_we),
    .o_dc_addr              (o_dc_addr),
    .o_dc_sel               (o_dc_sel),
    .o_dc_wdata             (o_dc_wdata),
    .i_dc_ack               (ack),
    .i_dc_err               (err),
    .i_dc_rdata             (rdata),
    .o_data_stall           (o_data_stall),
    .o_rd_data              (o_rd_data),
    .o_fault                (o_fault),
    .o_fault_cause          (o_fault_cause)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model of the visible behaviour.
  int          m_phase, m_wait;
  logic        m_stb, m_we, m_load, m_fault;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [3:0]  m_sel;
  logic [1:0]  m_cause;
  logic        e_stall;
  bit          checking = 0;
  int          rsp = -1;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] s, input logic [31:0] a);
    int n   = nbytes(s);
    int off = int'(a % 32'd4);
    int base = off - (off % n);
    return 4'(((1 << n) - 1) << base);
  endfunction

  function automatic logic [31:0] repl(input logic [1:0] s, input logic [31:0] w);
    int n = nbytes(s);
    if (n == 4) return w;
    if (n == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
    return {24'h0, w[7:0]} * 32'h0101_0101;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    e_stall = !clear && ((m_phase == PH_IDLE && valid) || m_phase == PH_BUS);
    cmp("stall", o_data_stall, e_stall);
    cmp("stb",   o_dc_stb,     m_stb);
    cmp("we",    o_dc_we,      m_we);
    cmp("addr",  o_dc_addr,    m_addr);
    cmp("sel",   o_dc_sel,     m_sel);
    cmp("wdata", o_dc_wdata,   m_wdata);
    cmp("rd",    o_rd_data,    m_rd);
    cmp("fault", o_fault,      m_fault);
    cmp("cause", o_fault_cause, m_cause);
  endtask

  task automatic model_step();
    bit fin;
    if (reset) begin
      m_phase = PH_IDLE; m_wait = 0; m_stb = 0; m_we = 0; m_load = 0;
      m_addr = 0; m_sel = 0; m_wdata = 0; m_rd = 0; m_fault = 0; m_cause = 0;
    end else begin
      case (m_phase)
        PH_IDLE: if (valid && !clear && !cstall) begin
          if (ALIGN_CHK != 0 && (addr % 32'(nbytes(size))) != 0) begin
            m_phase = PH_RESULT; m_fault = 1; m_cause = 2;
          end else begin
            m_phase = PH_BUS; m_stb = 1; m_we = !load; m_load = load;
            m_addr = addr & ~32'h3; m_sel = lanes(size, addr);
            m_wdata = repl(size, wdata); m_wait = 0;
          end
        end
        PH_BUS, PH_DRAIN: begin
          fin = ack || err || (TIMEOUT_CYCLES != 0 && m_wait + 1 == TIMEOUT_CYCLES);
          if (fin) begin
            m_stb = 0;
            if (m_phase == PH_BUS && !clear) begin
              m_phase = PH_RESULT;
              if (err) begin m_fault = 1; m_cause = 1; end
              else if (ack) begin if (m_load) m_rd = rdata; end
              else begin m_fault = 1; m_cause = 3; end
            end else begin
              m_phase = PH_IDLE;
            end
          end else begin
            m_wait++;
            if (clear) m_phase = PH_DRAIN;
          end
        end
        default: if (clear || !cstall) begin
          m_phase = PH_IDLE; m_fault = 0; m_cause = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    #1;
    if (checking) check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic req(input logic l, input logic [31:0] a, input logic [1:0] s,
                     input logic [31:0] w);
    valid = 1; load = l; addr = a; size = s; wdata = w;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; clear = 0; cstall = 0; valid = 0; load = 0; ack = 0; err = 0;
    addr = 0; wdata = 0; rdata = 0; size = 0;
    @(negedge clk);
    tick();
    checking = 1;
    tick();
    reset = 0;
    #1;
    cmp("rst_stb", o_dc_stb, 0);   cmp("rst_sel", o_dc_sel, 0);
    cmp("rst_rd", o_rd_data, 0);   cmp("rst_cause", o_fault_cause, 0);

    // Load word with three-cycle ack.
    req(1, 32'h100, 2'd0, 0);
    tick();
    cmp("lw_sel", o_dc_sel, 4'hF); cmp("lw_addr", o_dc_addr, 32'h100); cmp("lw_stb", o_dc_stb, 1);
    tick(); tick();
    ack = 1; rdata = 32'hDEADBEEF;
    tick();
    ack = 0; valid = 0; #1;
    cmp("lw_rd", o_rd_data, 32'hDEADBEEF); cmp("lw_stall", o_data_stall, 0); cmp("lw_stb_off", o_dc_stb, 0);
    tick();

    // Store byte to lane 3.
    req(0, 32'h203, 2'd2, 32'h0000_00A5);
    tick();
    cmp("sb_sel", o_dc_sel, 4'b1000); cmp("sb_wdata", o_dc_wdata, 32'hA5A5A5A5); cmp("sb_we", o_dc_we, 1);
    ack = 1; tick();
    ack = 0; valid = 0; #1;
    cmp("sb_rd_kept", o_rd_data, 32'hDEADBEEF);
    tick();

    // Misaligned half load.
    req(1, 32'h101, 2'd1, 0);
    tick();
    valid = 0; #1;
    cmp("mis_stb", o_dc_stb, 0); cmp("mis_fault", o_fault, 1); cmp("mis_cause", o_fault_cause, 2);
    tick();

    // Error and ack together.
    req(1, 32'h10, 2'd0, 0);
    tick();
    ack = 1; err = 1; rdata = 32'h0BAD_0BAD;
    tick();
    ack = 0; err = 0; valid = 0; #1;
    cmp("err_cause", o_fault_cause, 1); cmp("err_rd", o_rd_data, 32'hDEADBEEF);
    tick();

    // Timeout with no ack.
    req(1, 32'h20, 2'd0, 0);
    tick();
    repeat (TIMEOUT_CYCLES - 1) tick();
    cmp("to_stb_hold", o_dc_stb, 1);
    tick();
    valid = 0; #1;
    cmp("to_stb", o_dc_stb, 0); cmp("to_cause", o_fault_cause, 3);
    tick();

    // Flush during ACCESS.
    req(1, 32'h40, 2'd0, 0);
    tick();
    clear = 1; #1;
    cmp("fl_stall", o_data_stall, 0);
    tick();
    clear = 0; valid = 0; #1;
    cmp("fl_stb", o_dc_stb, 1); cmp("fl_stall2", o_data_stall, 0);
    tick();
    ack = 1; rdata = 32'h0000_0BAD;
    tick();
    ack = 0; #1;
    cmp("fl_stb_off", o_dc_stb, 0); cmp("fl_fault", o_fault, 0); cmp("fl_rd", o_rd_data, 32'hDEADBEEF);
    tick();

    // Code stall held in DONE.
    req(1, 32'h80, 2'd0, 0);
    tick();
    ack = 1; rdata = 32'h1234_5678;
    tick();
    ack = 0; valid = 0; cstall = 1;
    repeat (4) begin
      #1; cmp("cs_rd", o_rd_data, 32'h1234_5678);
      tick();
    end
    cstall = 0;
    tick();

    // Reset mid-ACCESS.
    req(1, 32'h90, 2'd0, 0);
    tick();
    reset = 1;
    tick();
    reset = 0; valid = 0; #1;
    cmp("rm_stb", o_dc_stb, 0); cmp("rm_rd", o_rd_data, 0);
    tick();

    // Randomized traffic with a randomly timed responder.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!e_stall) begin
        valid = ($urandom_range(0, 3) != 0);
        load  = 1'($urandom_range(0, 1));
        addr  = $urandom;
        size  = 2'($urandom_range(0, 3));
        wdata = $urandom;
      end
      cstall = ($urandom_range(0, 3) == 0);
      ack = 0; err = 0; rdata = $urandom;
      if (m_stb) begin
        if (rsp < 0) rsp = $urandom_range(0, 5);
        if (rsp == 0) begin
          case ($urandom_range(0, 7))
            0:       err = 1;
            1:       begin err = 1; ack = 1; end
            default: ack = 1;
          endcase
          rsp = -1;
        end else begin
          rsp--;
        end
      end else begin
        rsp = -1;
      end
      clear = !ack && !err && ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
